// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
// Shared definitions for the instruction fetch unit: word width, reset
// fetch address default, HLT opcode match constants, FSM state encoding
// and the instruction-queue entry layout.
package fetch_unit_pkg;

    localparam int WORD_W = 16;

    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 16'h0000;

    // HLT is recognised by its major opcode and function field only;
    // the remaining bits are don't-care.
    localparam logic [1:0] HLT_OP = 2'b11;
    localparam logic [3:0] HLT_FN = 4'b1111;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_t;

    // One queued instruction together with its successor address.
    typedef struct packed {
        logic [WORD_W-1:0] inst;
        logic [WORD_W-1:0] pc1;
    } qentry_t;

    function automatic logic is_hlt(input logic [WORD_W-1:0] inst);
        return (inst[15:14] == HLT_OP) && (inst[7:4] == HLT_FN);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue
// Two-entry FIFO holding fetched instructions between the memory return
// and the IF/ID boundary. Push and pop in the same cycle both take effect;
// flush empties the queue and overrides push and pop.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_data   write one entry at the tail
//   pop               drop the head entry
//   flush             discard every entry
//   head              head entry, all zeros when empty
//   full, empty       occupancy flags
module fetch_queue
    import fetch_unit_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  qentry_t push_data,
    input  logic    pop,
    input  logic    flush,
    output qentry_t head,
    output logic    full,
    output logic    empty
);

    localparam int DEPTH = 2;

    qentry_t    entry_reg [DEPTH];
    logic       rd_ptr_reg;
    logic       wr_ptr_reg;
    logic [1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else if (flush) begin
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg[gi] <= '0;
                end else if (push && !flush && (wr_ptr_reg == 1'(gi))) begin
                    entry_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    assign empty = (count_reg == 2'd0);
    assign full  = (count_reg == 2'd2);
    // An empty queue presents a zero word so IF/ID sees a NOP bubble.
    assign head  = empty ? '0 : entry_reg[rd_ptr_reg];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage: issues one memory read per cycle into a 2-entry
// queue, delivers the queue head to IF/ID, handles redirects (flush with
// epoch squash of the in-flight return) and stops fetching on HLT.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   ce                       run enable; gates new issue only
//   redirect, redirect_pc    taken branch: flush and refetch from target
//   id_ready                 decode accepts the head this cycle
//   imem_addr, imem_req      memory request (address is the fetch PC)
//   imem_q                   memory data, one cycle after imem_req
//   if_inst, if_pc1, if_valid  head instruction, its address + 1, valid
//   halted                   fetch stopped on HLT
//   pc_dbg                   next fetch address for display
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                QDEPTH   = 2,
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              id_ready,
    output logic [WORD_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic [WORD_W-1:0] imem_q,
    output logic [WORD_W-1:0] if_inst,
    output logic [WORD_W-1:0] if_pc1,
    output logic              if_valid,
    output logic              halted,
    output logic [WORD_W-1:0] pc_dbg
);

    localparam logic [2:0] QDEPTH_L = 3'(QDEPTH);

    fetch_state_t      state_reg;
    logic [WORD_W-1:0] pc_reg;
    logic              epoch_reg;
    logic              inflight_reg;
    logic              inflight_epoch_reg;
    logic [WORD_W-1:0] inflight_pc1_reg;

    logic    issue;
    logic    push;
    logic    pop;
    logic    q_full;
    logic    q_empty;
    qentry_t q_head;
    qentry_t push_data;
    logic [2:0] occupancy;
    logic [2:0] committed;

    assign occupancy = q_full ? 3'd2 : (q_empty ? 3'd0 : 3'd1);
    assign pop       = !q_empty && id_ready;
    // Slots already spoken for once this cycle's pop is taken into account;
    // counting the in-flight return keeps the queue from ever overflowing.
    assign committed = occupancy + {2'b00, inflight_reg} - {2'b00, pop};

    // rst_n is included so no request leaves the unit while reset is held.
    assign issue = rst_n && ce && (state_reg == ST_RUN) && !redirect
                   && (committed < QDEPTH_L);

    // A return is dropped if a redirect happened since it was issued, if a
    // redirect arrives now, or if HLT was already pushed (state HALTED).
    assign push = inflight_reg && (inflight_epoch_reg == epoch_reg)
                  && (state_reg == ST_RUN) && !redirect;

    assign push_data = '{inst: imem_q, pc1: inflight_pc1_reg};

    fetch_queue u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= ST_RUN;
            pc_reg             <= RESET_PC;
            epoch_reg          <= 1'b0;
            inflight_reg       <= 1'b0;
            inflight_epoch_reg <= 1'b0;
            inflight_pc1_reg   <= '0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                inflight_epoch_reg <= epoch_reg;
                inflight_pc1_reg   <= pc_reg + 16'd1;
            end
            if (redirect) begin
                pc_reg    <= redirect_pc;
                epoch_reg <= ~epoch_reg;
                state_reg <= ST_RUN;
            end else begin
                if (issue) begin
                    pc_reg <= pc_reg + 16'd1;
                end
                if (push && is_hlt(imem_q)) begin
                    state_reg <= ST_HALTED;
                end
            end
        end
    end

    assign imem_addr = pc_reg;
    assign imem_req  = issue;
    assign if_inst   = q_head.inst;
    assign if_pc1    = q_head.pc1;
    assign if_valid  = !q_empty;
    assign halted    = (state_reg == ST_HALTED);
    assign pc_dbg    = pc_reg;

endmodule
